// File: rtl/kmp_stream_matcher.sv
// kmp_stream_matcher: Knuth-Morris-Pratt streaming string matcher.
// The pattern is written into an internal RAM. A start pulse builds the
// failure (prefix) table in BUILD, then text is streamed in MATCH over a
// valid/ready handshake.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   pat_we/addr/data pattern RAM write port (IDLE only)
//   pat_len         pattern length, sampled on start
//   start           begin a run (IDLE only)
//   txt_valid/data/last, txt_ready   text stream handshake (txt_ready is combinational)
//   match_valid     one-cycle pulse per match
//   match_pos       text index of the first character of the last match
//   match_count     saturating match count since the last start
//   busy            high in BUILD and MATCH
//   done            one-cycle pulse at end of run
//   err             invalid pat_len at start; held until the next start
//
// Build option: define KMP_NOOVERLAP_EN to restart the search at pattern
// index 0 after a match (non-overlapping matches only).
`timescale 1ns/1ps
module kmp_stream_matcher #(
  parameter int unsigned CHAR_W  = 8,
  parameter int unsigned MAX_PAT = 16,
  parameter int unsigned POS_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pat_we,
  input  logic [$clog2(MAX_PAT)-1:0]   pat_addr,
  input  logic [CHAR_W-1:0]            pat_data,
  input  logic [$clog2(MAX_PAT+1)-1:0] pat_len,
  input  logic                         start,
  input  logic                         txt_valid,
  input  logic [CHAR_W-1:0]            txt_data,
  input  logic                         txt_last,
  output logic                         txt_ready,
  output logic                         match_valid,
  output logic [POS_W-1:0]             match_pos,
  output logic [POS_W-1:0]             match_count,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned ADDR_W = $clog2(MAX_PAT);
  localparam int unsigned LEN_W  = $clog2(MAX_PAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUILD = 2'd1;
  localparam logic [1:0] S_MATCH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CHAR_W-1:0] pat_mem  [MAX_PAT];
  logic [LEN_W-1:0]  fail_mem [MAX_PAT];
  logic [LEN_W-1:0]  len_q, i_q, k_q, j_q;
  logic [POS_W-1:0]  txt_pos_q;

  logic             len_bad_c, bld_eq_c, bld_adv_c, bld_fin_c;
  logic             chr_eq_c, at_end_c, accept_c, hit_c, fallback_c;
  logic [LEN_W-1:0] j_after_hit_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, handshake and datapath decode
  always_comb begin
    state_d   = state_q;
    txt_ready = 1'b0;
    len_bad_c = (pat_len == '0) || (32'(pat_len) > MAX_PAT);
    bld_eq_c  = pat_mem[ADDR_W'(i_q)] == pat_mem[ADDR_W'(k_q)];
    // A build step that writes fail[i] also advances i; the last such step ends BUILD.
    bld_adv_c = bld_eq_c || (k_q == '0);
    bld_fin_c = (i_q == len_q) || (bld_adv_c && ((i_q + LEN_W'(1)) == len_q));
    chr_eq_c  = txt_data == pat_mem[ADDR_W'(j_q)];
    at_end_c  = j_q == (len_q - LEN_W'(1));
`ifdef KMP_NOOVERLAP_EN
    j_after_hit_c = '0;
`else
    j_after_hit_c = fail_mem[ADDR_W'(len_q - LEN_W'(1))];
`endif
    case (state_q)
      S_IDLE:  if (start) state_d = len_bad_c ? S_DONE : S_BUILD;
      S_BUILD: if (bld_fin_c) state_d = S_MATCH;
      S_MATCH: begin
        // A mismatch with j>0 stalls the character so it is re-compared after fallback.
        txt_ready = txt_valid && (chr_eq_c || (j_q == '0));
        if (txt_ready && txt_last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    accept_c   = txt_ready;
    hit_c      = accept_c && chr_eq_c && at_end_c;
    fallback_c = (state_q == S_MATCH) && txt_valid && !chr_eq_c && (j_q != '0);
  end

  // Pattern RAM and failure table (not reset)
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && pat_we && (32'(pat_addr) < MAX_PAT))
      pat_mem[pat_addr] <= pat_data;
    if ((state_q == S_IDLE) && start && !len_bad_c)
      fail_mem[0] <= '0;
    if ((state_q == S_BUILD) && (i_q != len_q) && bld_adv_c)
      fail_mem[ADDR_W'(i_q)] <= bld_eq_c ? (k_q + LEN_W'(1)) : '0;
  end

  // Indices, text position and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= '0;
      i_q         <= '0;
      k_q         <= '0;
      j_q         <= '0;
      txt_pos_q   <= '0;
      match_valid <= 1'b0;
      match_pos   <= '0;
      match_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      match_valid <= hit_c;
      done        <= state_d == S_DONE;
      busy        <= (state_d == S_BUILD) || (state_d == S_MATCH);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (len_bad_c) begin
              err <= 1'b1;
            end else begin
              err         <= 1'b0;
              len_q       <= pat_len;
              match_count <= '0;
              match_pos   <= '0;
              txt_pos_q   <= '0;
              i_q         <= LEN_W'(1);
              k_q         <= '0;
              j_q         <= '0;
            end
          end
        end
        S_BUILD: begin
          if (i_q != len_q) begin
            if (bld_eq_c) begin
              k_q <= k_q + LEN_W'(1);
              i_q <= i_q + LEN_W'(1);
            end else if (k_q != '0) begin
              k_q <= fail_mem[ADDR_W'(k_q - LEN_W'(1))];
            end else begin
              i_q <= i_q + LEN_W'(1);
            end
          end
        end
        S_MATCH: begin
          if (accept_c) begin
            txt_pos_q <= txt_pos_q + POS_W'(1);
            if (chr_eq_c) j_q <= at_end_c ? j_after_hit_c : (j_q + LEN_W'(1));
          end else if (fallback_c) begin
            j_q <= fail_mem[ADDR_W'(j_q - LEN_W'(1))];
          end
          if (hit_c) begin
            match_pos <= txt_pos_q - POS_W'(len_q) + POS_W'(1);
            if (match_count != '1) match_count <= match_count + POS_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kmp_stream_matcher.sv
// Testbench for kmp_stream_matcher: table of streaming scenarios plus
// hand-written sequences for invalid length, mid-run reset and saturation.
`timescale 1ns/1ps
module tb_kmp_stream_matcher;

  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned MAX_PAT = 16;
  localparam int unsigned POS_W   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              pat_we;
  logic [3:0]        pat_addr;
  logic [CHAR_W-1:0] pat_data;
  logic [4:0]        pat_len;
  logic              start;
  logic              txt_valid;
  logic [CHAR_W-1:0] txt_data;
  logic              txt_last;
  logic              txt_ready;
  logic              match_valid;
  logic [POS_W-1:0]  match_pos;
  logic [POS_W-1:0]  match_count;
  logic              busy;
  logic              done;
  logic              err;

  kmp_stream_matcher #(.CHAR_W(CHAR_W), .MAX_PAT(MAX_PAT), .POS_W(POS_W)) dut (
    .clk(clk), .rst(rst),
    .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data), .pat_len(pat_len),
    .start(start),
    .txt_valid(txt_valid), .txt_data(txt_data), .txt_last(txt_last), .txt_ready(txt_ready),
    .match_valid(match_valid), .match_pos(match_pos), .match_count(match_count),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    string pat;
    string txt;
    int    gap;
    int    exp_cnt;
    int    exp_first;
    int    exp_last;
    int    exp_stalls;
    int    exp_first_stall;
  } vec_t;

  vec_t tbl[5];

  int n_tests = 0;
  int n_fail  = 0;
  int mv_cnt, done_cnt, busy_seen, ready_bad;
  int first_pos, last_pos;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int idx, input string name, input string p, input string t,
                         input int gap, input int cnt, input int first, input int last,
                         input int stalls, input int fs);
    tbl[idx].name = name;  tbl[idx].pat = p;  tbl[idx].txt = t;  tbl[idx].gap = gap;
    tbl[idx].exp_cnt = cnt;  tbl[idx].exp_first = first;  tbl[idx].exp_last = last;
    tbl[idx].exp_stalls = stalls;  tbl[idx].exp_first_stall = fs;
  endtask

  task automatic clr_mon();
    mv_cnt = 0; done_cnt = 0; busy_seen = 0; ready_bad = 0; first_pos = -1; last_pos = -1;
  endtask

  // One cycle: sample registered outputs, drive text inputs, report accept.
  task automatic step(input logic v, input logic [CHAR_W-1:0] d, input logic l, output logic acc);
    @(negedge clk);
    if (match_valid) begin
      mv_cnt++;
      if (mv_cnt == 1) first_pos = int'(match_pos);
      last_pos = int'(match_pos);
    end
    if (done) done_cnt++;
    if (busy) busy_seen = 1;
    txt_valid = v; txt_data = d; txt_last = l;
    #1;
    acc = txt_valid & txt_ready;
    if (!v && txt_ready) ready_bad++;
  endtask

  task automatic load_pat(input string p);
    for (int i = 0; i < p.len(); i++) begin
      @(negedge clk);
      pat_we = 1'b1; pat_addr = 4'(i); pat_data = p[i];
    end
    @(negedge clk);
    pat_we = 1'b0;
  endtask

  task automatic do_start(input int len);
    @(negedge clk);
    pat_len = 5'(len); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_stream(input string txt, input int gap,
                            output int stalls, output int first_stall, output int ok);
    logic acc;
    logic v;
    int   ci;
    int   cyc;
    bit   seen;
    ci = 0; cyc = 0; seen = 0; stalls = 0; first_stall = -1;
    while (ci < txt.len() && cyc < 1000) begin
      v = (gap == 0) || (cyc % 2 == 0);
      step(v, txt[ci], (ci == txt.len() - 1), acc);
      if (v && !acc && seen) begin
        stalls++;
        if (first_stall < 0) first_stall = ci;
      end
      if (acc) begin
        seen = 1;
        ci++;
      end
      cyc++;
    end
    ok = (ci == txt.len()) ? 1 : 0;
    repeat (3) step(1'b0, '0, 1'b0, acc);
  endtask

  initial begin
    int   stalls, fs, ok, ci, cyc;
    logic acc;

    set_vec(0, "abab",     "ABAB",   "ABABAB",     0, 2, 0, 2, 0, -1);
    set_vec(1, "abab_gap", "ABAB",   "ABABAB",     1, 2, 0, 2, 0, -1);
    set_vec(2, "aabaaa",   "AABAAA", "AABAABAAAA", 0, 1, 3, 3, 2,  5);
    set_vec(3, "aaa",      "AAA",    "AAAAA",      0, 3, 0, 2, 0, -1);
    set_vec(4, "xyz",      "XYZ",    "XYXYZ",      0, 1, 2, 2, 1,  2);
`ifdef KMP_NOOVERLAP_EN
    set_vec(0, "abab",     "ABAB",   "ABABAB",     0, 1, 0, 0, 0, -1);
    set_vec(1, "abab_gap", "ABAB",   "ABABAB",     1, 1, 0, 0, 0, -1);
    set_vec(3, "aaa",      "AAA",    "AAAAA",      0, 1, 0, 0, 0, -1);
`endif

    rst = 1'b1; pat_we = 1'b0; pat_addr = '0; pat_data = '0; pat_len = '0; start = 1'b0;
    txt_valid = 1'b0; txt_data = '0; txt_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_match_valid", match_valid, 0);
    check("rst_match_pos",   match_pos,   0);
    check("rst_match_count", match_count, 0);
    check("rst_busy",        busy,        0);
    check("rst_done",        done,        0);
    check("rst_err",         err,         0);
    rst = 1'b0;

    // Streaming scenarios
    for (int t = 0; t < 5; t++) begin
      load_pat(tbl[t].pat);
      clr_mon();
      do_start(tbl[t].pat.len());
      run_stream(tbl[t].txt, tbl[t].gap, stalls, fs, ok);
      check({tbl[t].name, "_complete"},    ok,          1);
      check({tbl[t].name, "_pulses"},      mv_cnt,      tbl[t].exp_cnt);
      check({tbl[t].name, "_count"},       match_count, tbl[t].exp_cnt);
      check({tbl[t].name, "_first_pos"},   first_pos,   tbl[t].exp_first);
      check({tbl[t].name, "_last_pos"},    last_pos,    tbl[t].exp_last);
      check({tbl[t].name, "_stalls"},      stalls,      tbl[t].exp_stalls);
      check({tbl[t].name, "_first_stall"}, fs,          tbl[t].exp_first_stall);
      check({tbl[t].name, "_done"},        done_cnt,    1);
      check({tbl[t].name, "_ready_idle"},  ready_bad,   0);
      check({tbl[t].name, "_busy_end"},    busy,        0);
      check({tbl[t].name, "_err"},         err,         0);
    end

    // Invalid pattern lengths
    clr_mon();
    do_start(0);
    step(1'b0, '0, 1'b0, acc);
    check("len0_done_next", done_cnt, 1);
    check("len0_err",       err,      1);
    repeat (2) step(1'b0, '0, 1'b0, acc);
    check("len0_done_once", done_cnt, 1);
    check("len0_no_busy",   busy_seen, 0);
    clr_mon();
    do_start(MAX_PAT + 1);
    step(1'b0, '0, 1'b0, acc);
    check("len17_done_next", done_cnt, 1);
    check("len17_err",       err,      1);
    repeat (2) step(1'b0, '0, 1'b0, acc);
    check("len17_done_once", done_cnt, 1);
    check("len17_no_busy",   busy_seen, 0);
    check("len17_err_held",  err,      1);

    // Reset in the middle of MATCH, then rerun without reloading the pattern
    load_pat("ABAB");
    clr_mon();
    do_start(4);
    ci = 0; cyc = 0;
    while (ci < 3 && cyc < 100) begin
      step(1'b1, (ci % 2 == 0) ? 8'h41 : 8'h42, 1'b0, acc);
      if (acc) ci++;
      cyc++;
    end
    check("midrst_accepts", ci, 3);
    @(negedge clk);
    txt_data = 8'h42; txt_valid = 1'b1;
    #1;
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_busy",  busy,        0);
    check("midrst_ready", txt_ready,   0);
    check("midrst_mv",    match_valid, 0);
    check("midrst_done",  done,        0);
    check("midrst_count", match_count, 0);
    txt_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr_mon();
    repeat (4) step(1'b0, '0, 1'b0, acc);
    check("midrst_no_done", done_cnt,  0);
    check("midrst_idle",    busy_seen, 0);
    clr_mon();
    do_start(4);
    run_stream("ABABAB", 0, stalls, fs, ok);
    check("rerun_complete", ok,          1);
    check("rerun_count",    match_count, tbl[0].exp_cnt);
    check("rerun_last_pos", last_pos,    tbl[0].exp_last);
    check("rerun_done",     done_cnt,    1);

    // Saturation and position wrap with a single-character pattern
    load_pat("A");
    clr_mon();
    do_start(1);
    ci = 0; cyc = 0;
    while (ci < 65537 && cyc < 70000) begin
      step(1'b1, 8'h41, 1'b0, acc);
      if (acc) ci++;
      cyc++;
    end
    check("sat_accepts", ci, 65537);
    step(1'b0, '0, 1'b0, acc);
    check("sat_count",    match_count, 65535);
    check("sat_pos_wrap", match_pos,   0);
    check("sat_busy",     busy,        1);
    cyc = 0;
    acc = 1'b0;
    while (!acc && cyc < 20) begin
      step(1'b1, 8'h41, 1'b1, acc);
      cyc++;
    end
    check("sat_last_accept", acc, 1);
    repeat (3) step(1'b0, '0, 1'b0, acc);
    check("sat_pulses",      mv_cnt,      65538);
    check("sat_count_final", match_count, 65535);
    check("sat_pos_final",   match_pos,   1);
    check("sat_done",        done_cnt,    1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/kmp_stream_matcher.md
Name: kmp_stream_matcher

Overview:
- Parametrised Knuth-Morris-Pratt string matcher with its own datapath: pattern RAM, an internally built failure (prefix) table, and a streaming text input with valid/ready handshake.
- Reports every match position and a running match count.
- Sits between the character source (UART/ROM reader) and the result display/registers.
- Replaces the fixed controller-only KMP FSM plus external counters.

Parameters:
- CHAR_W, 8, width of one character in bits.
- MAX_PAT, 16, maximum pattern length (pattern RAM depth).
- POS_W, 16, width of the text position, match position and match count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- pat_we  in  1  pattern RAM write strobe; ignored unless state is IDLE.
- pat_addr  in  $clog2(MAX_PAT)  pattern RAM write address.
- pat_data  in  CHAR_W  pattern character to write.
- pat_len  in  $clog2(MAX_PAT+1)  pattern length; sampled on start.
- start  in  1  one-cycle pulse; begins BUILD; ignored unless IDLE.
- txt_valid  in  1  text character valid.
- txt_data  in  CHAR_W  text character.
- txt_last  in  1  marks the final text character; qualified by the handshake.
- txt_ready  out  1  matcher accepts the text character this cycle.
- match_valid  out  1  one-cycle pulse per match found.
- match_pos  out  POS_W  text index of the first character of the match; held until the next match.
- match_count  out  POS_W  matches found since the last start.
- busy  out  1  high in BUILD and MATCH.
- done  out  1  one-cycle pulse at end of run.
- err  out  1  pat_len invalid at start; held until the next start.

Behaviour:
- Reset (async): state IDLE; all outputs 0; j, i, k, text position cleared. Pattern RAM and failure table are not reset. After a reset, a new start is required; reset mid-BUILD or mid-MATCH aborts with no done pulse.
- States: IDLE, BUILD, MATCH, DONE.
- IDLE:
  - start with pat_len==0 or pat_len>MAX_PAT -> err=1, go to DONE.
  - Other start -> latch len, clear match_count, match_pos, err and text position; fail[0]=0, i=1, k=0; go to BUILD.
- BUILD: one step per cycle.
  - pat[i]==pat[k]: fail[i]=k+1, k++, i++.
  - Else if k>0: k=fail[k-1].
  - Else: fail[i]=0, i++.
  - When i==len (len==1 skips BUILD in one cycle), go to MATCH with j=0.
- MATCH: txt_ready is combinational.
  - txt_data==pat[j]: txt_ready=1.
    - If j==len-1: match; j=fail[len-1] (overlapping).
    - Else: j++.
  - txt_data!=pat[j] and j>0: txt_ready=0; j=fail[j-1]; the same character is re-compared next cycle.
  - txt_data!=pat[j] and j==0: txt_ready=1; j stays 0.
  - txt_valid=0: txt_ready=0; no state change.
- Accept = txt_valid & txt_ready. Each accept increments the text position (wraps modulo 2^POS_W).
- On a match-accept at position p:
  - Next cycle: match_valid=1 and match_pos=p-len+1 (mod 2^POS_W).
  - match_count increments, saturating at 2^POS_W-1.
- Accepted txt_last -> DONE. The match_valid for that character is still emitted.
- DONE: done=1 for one cycle; busy=0; go to IDLE.
- Latency: match_valid is 1 cycle after the accepting edge. BUILD takes len-1 to 2*(len-1) cycles.
- A start pulse outside IDLE, and pat_we outside IDLE, are ignored.

Optional Feature:
- Macro KMP_NOOVERLAP_EN.
- Defined: on a match, j resets to 0 (non-overlapping matches only).
- Undefined: j=fail[len-1] (overlapping matches). All other behaviour is identical.

Test Plan:
- Pattern "ABAB", len 4; stream "ABABAB" with txt_last on the final char -> match_valid at pos 0 and 2, match_count=2, one done pulse. With KMP_NOOVERLAP_EN: only pos 0, count=1.
- Pattern "AABAAA" (expected fail = 0,1,0,1,2,2); text "AABAABAAAA" -> exactly one match at pos 3, count=1; txt_ready=0 on fallback cycles (the mismatch at text index 5, where j=5).
- Same as the first scenario with txt_valid dropped every other cycle -> identical matches and count; no character accepted while txt_valid=0.
- start with pat_len=0, then pat_len=MAX_PAT+1 -> err=1, done pulse 1 cycle later, busy never high.
- rst asserted mid-MATCH after 3 accepted chars -> outputs 0 immediately. A fresh start of the first scenario then gives count=2 with pattern RAM intact.
- Text of all 'A' (2^POS_W+2 chars) with pattern "A" -> match_count saturates at 2^POS_W-1 and match_pos wraps to 0.
